// File: rtl/alu_bit_serial_seq_if.sv
// Bundle between the bit-serial ALU sequencer, its CPU-side requester and the 1-bit slice.
// slave is the sequencer itself; master is the side that requests ops and hosts the slice.
interface alu_bit_serial_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             err;
  logic             s_a;
  logic             s_b;
  logic             s_cin;
  logic             s_binvert;
  logic             s_less;
  logic [2:0]       s_op;
  logic             s_result;
  logic             s_cout;

  modport slave (
    input  start, op, a, b, s_result, s_cout,
    output busy, done, result, carry, overflow, zero, err,
           s_a, s_b, s_cin, s_binvert, s_less, s_op
  );

  modport master (
    output start, op, a, b, s_result, s_cout,
    input  busy, done, result, carry, overflow, zero, err,
           s_a, s_b, s_cin, s_binvert, s_less, s_op
  );
endinterface

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: drives one 1-bit slice LSB first to build a full WIDTH-bit result.
// SLT takes a second pass that feeds the computed set bit back through the slice's Less path.
module alu_bit_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_bit_serial_seq_if.slave bus
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, SLT2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, result_r, result_nx;
  logic [2:0]       op_r;
  logic [IW-1:0]    idx;
  logic             carry_r, set_r;
  logic             done_r, err_r, carry_o, ovf_o, zero_o;
  logic             legal, arith, inv, last;

  assign legal     = (op_r < 3'd6);
  assign arith     = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign inv       = (op_r == OP_SUB) || (op_r == OP_SLT);
  assign last      = (idx == LAST_IDX);
  assign result_nx = {bus.s_result, result_r[WIDTH-1:1]};

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.result   = result_r;
  assign bus.carry    = carry_o;
  assign bus.overflow = ovf_o;
  assign bus.zero     = zero_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Slice drive is purely a function of state; an illegal op leaves the slice quiet.
  always_comb begin
    state_nx      = state;
    bus.s_a       = 1'b0;
    bus.s_b       = 1'b0;
    bus.s_cin     = 1'b0;
    bus.s_binvert = 1'b0;
    bus.s_less    = 1'b0;
    bus.s_op      = 3'b000;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = RUN;
      end
      RUN: begin
        if (!legal) begin
          state_nx = IDLE;
        end else begin
          bus.s_a       = a_sh[0];
          bus.s_b       = b_sh[0];
          bus.s_cin     = carry_r;
          bus.s_binvert = inv;
          case (op_r)
            OP_AND:  bus.s_op = 3'b000;
            OP_OR:   bus.s_op = 3'b010;
            OP_XOR:  bus.s_op = 3'b011;
            default: bus.s_op = 3'b100;
          endcase
          if (last) state_nx = (op_r == OP_SLT) ? SLT2 : IDLE;
        end
      end
      SLT2: begin
        bus.s_op   = 3'b001;
        bus.s_less = set_r && (idx == '0);
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      result_r <= '0;
      op_r     <= '0;
      idx      <= '0;
      carry_r  <= 1'b0;
      set_r    <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      carry_o  <= 1'b0;
      ovf_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            op_r    <= bus.op;
            idx     <= '0;
            carry_r <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
            err_r   <= 1'b0;
          end
        end
        RUN: begin
          if (!legal) begin
            done_r   <= 1'b1;
            err_r    <= 1'b1;
            result_r <= '0;
            zero_o   <= 1'b1;
            carry_o  <= 1'b0;
            ovf_o    <= 1'b0;
          end else begin
            result_r <= result_nx;
            carry_r  <= bus.s_cout;
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            idx      <= idx + IW'(1);
            // MSB cycle: overflow is carry-in vs carry-out of the sign bit.
            if (last) begin
              idx <= '0;
              if (op_r == OP_SLT) begin
                set_r <= bus.s_result ^ (carry_r ^ bus.s_cout);
              end else begin
                done_r  <= 1'b1;
                carry_o <= arith & bus.s_cout;
                ovf_o   <= arith & (carry_r ^ bus.s_cout);
                zero_o  <= (result_nx == '0);
              end
            end
          end
        end
        SLT2: begin
          result_r <= result_nx;
          idx      <= idx + IW'(1);
          if (last) begin
            done_r  <= 1'b1;
            carry_o <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= (result_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Self-checking bench: hosts a behavioural 1-bit slice, compares every cycle against a
// latency-countdown reference model, and pins the model with hand-computed cases.
module tb_alu_bit_serial_seq;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0;

  alu_bit_serial_seq_if #(.WIDTH(WIDTH)) bus();

  alu_bit_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural slice: B optionally inverted, full adder, op-selected result.
  logic bb;
  assign bb = bus.s_b ^ bus.s_binvert;
  assign bus.s_cout   = (bus.s_a & bb) | (bus.s_a & bus.s_cin) | (bb & bus.s_cin);
  assign bus.s_result = (bus.s_op == 3'b000) ? (bus.s_a & bb) :
                        (bus.s_op == 3'b001) ? bus.s_less :
                        (bus.s_op == 3'b010) ? (bus.s_a | bb) :
                        (bus.s_op == 3'b011) ? (bus.s_a ^ bb) :
                        (bus.s_op == 3'b100) ? (bus.s_a ^ bb ^ bus.s_cin) : 1'b0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Word-level reference: result/flags from plain arithmetic, plus the op's latency.
  function automatic void refOp(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] r, output logic c, output logic v,
                                output logic z, output logic e, output int lat);
    logic [WIDTH:0] s;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = WIDTH; s = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd4: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd5: begin
        r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
        lat = 2 * WIDTH;
      end
      default: begin e = 1'b1; lat = 1; end
    endcase
    z = (r == '0);
  endfunction

  logic             m_busy = 0, m_done = 0, m_err = 0, m_carry = 0, m_ovf = 0, m_zero = 0;
  logic [WIDTH-1:0] m_result = '0;
  logic             p_err, p_carry, p_ovf, p_zero;
  logic [WIDTH-1:0] p_result;
  int               m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_carry = 0; m_ovf = 0; m_zero = 0;
      m_result = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_result = p_result;
          m_carry = p_carry; m_ovf = p_ovf; m_zero = p_zero; m_err = p_err;
        end
      end else if (bus.start) begin
        refOp(bus.op, bus.a, bus.b, p_result, p_carry, p_ovf, p_zero, p_err, m_cnt);
        m_busy = 1; m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    cmp("busy",     32'(bus.busy),     32'(m_busy));
    cmp("done",     32'(bus.done),     32'(m_done));
    cmp("err",      32'(bus.err),      32'(m_err));
    cmp("carry",    32'(bus.carry),    32'(m_carry));
    cmp("overflow", 32'(bus.overflow), 32'(m_ovf));
    cmp("zero",     32'(bus.zero),     32'(m_zero));
    if (!m_busy) cmp("result", 32'(bus.result), 32'(m_result));
  end

  task automatic waitDone();
    while (bus.done !== 1'b1 && (cyc - t0) < 3 * WIDTH) begin
      @(posedge clk); #2;
    end
    if (bus.done !== 1'b1) begin
      errors++; checks++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, expected 1", bus.done, cyc - t0);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op_i, input logic [WIDTH-1:0] a_i,
                               input logic [WIDTH-1:0] b_i, input bit immediate);
    if (!immediate) begin @(posedge clk); #2; end
    bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
    @(posedge clk); #2;
    t0 = cyc;
    bus.start = 1'b0;
    waitDone();
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_r, input logic exp_c,
                             input logic exp_v, input logic exp_z, input logic exp_e, input int exp_lat);
    cmp({name, "_result"},   32'(bus.result),   32'(exp_r));
    cmp({name, "_model"},    32'(m_result),     32'(exp_r));
    cmp({name, "_carry"},    32'(bus.carry),    32'(exp_c));
    cmp({name, "_overflow"}, 32'(bus.overflow), 32'(exp_v));
    cmp({name, "_zero"},     32'(bus.zero),     32'(exp_z));
    cmp({name, "_err"},      32'(bus.err),      32'(exp_e));
    cmp({name, "_latency"},  32'(cyc - t0),     32'(exp_lat));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, er;
    logic [2:0]       rop;
    logic             ec, ev, ez, ee;
    int               elat;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #2;
    cmp("rst_busy",   32'(bus.busy),   0);
    cmp("rst_result", 32'(bus.result), 0);
    cmp("rst_s_op",   32'(bus.s_op),   0);
    rst_n = 1'b1;

    applyStimulus(3'd3, 16'h7FFF, 16'h0001, 0);
    checkOutput("add_ovf", 16'h8000, 0, 1, 0, 0, 16);
    applyStimulus(3'd4, 16'h0005, 16'h0005, 1);
    checkOutput("sub_eq", 16'h0000, 1, 0, 1, 0, 16);
    applyStimulus(3'd5, 16'h8000, 16'h0001, 0);
    checkOutput("slt_true", 16'h0001, 0, 0, 0, 0, 32);
    applyStimulus(3'd5, 16'h0001, 16'h8000, 0);
    checkOutput("slt_false", 16'h0000, 0, 0, 1, 0, 32);
    applyStimulus(3'd2, 16'hA5A5, 16'hFFFF, 0);
    checkOutput("xor", 16'h5A5A, 0, 0, 0, 0, 16);
    applyStimulus(3'd0, 16'hA5A5, 16'hFFFF, 0);
    checkOutput("and", 16'hA5A5, 0, 0, 0, 0, 16);
    applyStimulus(3'd1, 16'hA5A5, 16'hFFFF, 1);
    checkOutput("or", 16'hFFFF, 0, 0, 0, 0, 16);

    // Extra start pulses at T+3 and T+9 with different requests must be ignored.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 16'h1234; bus.b = 16'h1111;
    @(posedge clk); #2;
    t0 = cyc; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 bus.start = 1'b1; bus.op = 3'd2; bus.a = 16'hFFFF;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 bus.start = 1'b1; bus.op = 3'd5;
    @(posedge clk); #2 bus.start = 1'b0;
    waitDone();
    checkOutput("busy_ignore", 16'h2345, 0, 0, 0, 0, 16);

    // Reset mid-ADD, then an illegal op.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 16'h7FFF; bus.b = 16'h0001;
    @(posedge clk); #2;
    t0 = cyc; bus.start = 1'b0;
    while ((cyc - t0) < 7) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    cmp("abort_busy",   32'(bus.busy),   0);
    cmp("abort_result", 32'(bus.result), 0);
    cmp("abort_done",   32'(bus.done),   0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    applyStimulus(3'd7, 16'h1234, 16'h5678, 0);
    checkOutput("illegal", 16'h0000, 0, 0, 1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 9));
      if ($urandom_range(0, 9) > 7) rop = 3'd3;
      case ($urandom_range(0, 4))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        2: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rb = 16'h0000;
        1: rb = 16'h8000;
        2: rb = ra;
        default: rb = 16'($urandom);
      endcase
      refOp(rop, ra, rb, er, ec, ev, ez, ee, elat);
      applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)));
      cmp("rand_latency", 32'(cyc - t0), 32'(elat));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
